// File: rtl/core_pkg.sv
// Shared core types and sizing for the reorder buffer.
// Build option: define ROB_MISPRED_FLUSH_EN to make branch-mispredict
// completions flush the pipeline the same way exceptions do.
package core_pkg;

    localparam int NUM_ROB_ENTS = 64;
    localparam int DISP_WIDTH   = 2;
    localparam int RETIRE_WIDTH = 4;
    localparam int NUM_FUS      = 4;
    localparam int NUM_AREGS    = 32;
    localparam int NUM_PREGS    = 128;

    localparam int AREG_W = $clog2(NUM_AREGS);
    localparam int PREG_W = $clog2(NUM_PREGS);
    localparam int PC_W   = 32;

`ifdef ROB_MISPRED_FLUSH_EN
    localparam logic MISPRED_FLUSH = 1'b1;
`else
    localparam logic MISPRED_FLUSH = 1'b0;
`endif

    // Payload captured at dispatch.
    typedef struct packed {
        logic [AREG_W-1:0] areg;
        logic [PREG_W-1:0] preg;
        logic [PC_W-1:0]   pc;
    } rob_entry_t;

    // One retiring micro-op as presented to the rename/commit logic.
    typedef struct packed {
        logic              valid;
        logic [AREG_W-1:0] areg;
        logic [PREG_W-1:0] preg;
        logic [PC_W-1:0]   pc;
    } retire_uop_t;

    // A completion is flush-causing on an exception, and on a mispredict
    // only when mispredict flushing is built in.
    function automatic logic flush_cause(input logic exc, input logic mispred);
        return exc | (mispred & MISPRED_FLUSH);
    endfunction

endpackage

// File: rtl/rob_retire_sel.sv
// Retire-lane selection: a lane retires when it and every older lane in the
// window are allocated and done; selection stops after the first entry that
// carries a flush-causing flag, which becomes the flush lane.
module rob_retire_sel #(
    parameter int  RETIRE_WIDTH = 4,
    localparam int CW = $clog2(RETIRE_WIDTH + 1),
    localparam int LW = (RETIRE_WIDTH > 1) ? $clog2(RETIRE_WIDTH) : 1
) (
    input  logic [RETIRE_WIDTH-1:0] lane_valid,
    input  logic [RETIRE_WIDTH-1:0] lane_done,
    input  logic [RETIRE_WIDTH-1:0] lane_flag,
    output logic [RETIRE_WIDTH-1:0] ret_mask,
    output logic [CW-1:0]           ret_cnt,
    output logic                    flush,
    output logic [LW-1:0]           flush_lane
);

    logic open_s;

    // Prefix-AND of valid&done, closing the window after a flagged entry.
    always_comb begin
        ret_mask   = '0;
        ret_cnt    = '0;
        flush      = 1'b0;
        flush_lane = '0;
        open_s     = 1'b1;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            if (open_s && lane_valid[k] && lane_done[k]) begin
                ret_mask[k] = 1'b1;
                ret_cnt     = ret_cnt + CW'(1);
                if (lane_flag[k]) begin
                    flush      = 1'b1;
                    flush_lane = LW'(k);
                    open_s     = 1'b0;
                end else begin
                    open_s = 1'b1;
                end
            end else begin
                open_s = 1'b0;
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation at the tail, out-of-order
// completion by index, in-order retirement from the head with flush on
// flagged entries. Define ROB_MISPRED_FLUSH_EN to flush on mispredicts too.
module reorder_buffer #(
    parameter int  NUM_ROB_ENTS = core_pkg::NUM_ROB_ENTS,
    parameter int  DISP_WIDTH   = core_pkg::DISP_WIDTH,
    parameter int  RETIRE_WIDTH = core_pkg::RETIRE_WIDTH,
    parameter int  NUM_FUS      = core_pkg::NUM_FUS,
    parameter int  NUM_AREGS    = core_pkg::NUM_AREGS,
    parameter int  NUM_PREGS    = core_pkg::NUM_PREGS,
    localparam int IDXW = $clog2(NUM_ROB_ENTS),
    localparam int AW   = $clog2(NUM_AREGS),
    localparam int PW   = $clog2(NUM_PREGS)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [DISP_WIDTH-1:0]                  disp_valid,
    input  core_pkg::rob_entry_t [DISP_WIDTH-1:0]  disp_entry,
    output logic                                   disp_ready,
    output logic [DISP_WIDTH-1:0][IDXW-1:0]        disp_rob_idx,
    input  logic [NUM_FUS-1:0]                     cmpl_valid,
    input  logic [NUM_FUS-1:0][IDXW-1:0]           cmpl_rob_idx,
    input  logic [NUM_FUS-1:0]                     cmpl_exception,
    input  logic [NUM_FUS-1:0]                     cmpl_br_mispred,
    output logic [RETIRE_WIDTH-1:0]                ret_valid,
    output logic [RETIRE_WIDTH-1:0][AW-1:0]        ret_areg,
    output logic [RETIRE_WIDTH-1:0][PW-1:0]        ret_preg,
    output logic [RETIRE_WIDTH-1:0][31:0]          ret_pc,
    output logic                                   flush,
    output logic [31:0]                            flush_pc,
    output logic [IDXW:0]                          rob_count
);

    localparam int CW = $clog2(RETIRE_WIDTH + 1);
    localparam int LW = (RETIRE_WIDTH > 1) ? $clog2(RETIRE_WIDTH) : 1;

    // Pointers carry a wrap bit above the index so full and empty differ.
    logic [IDXW:0]             head_q, head_d, tail_q, tail_d;
    logic [NUM_ROB_ENTS-1:0]   valid_q, valid_d;
    logic [NUM_ROB_ENTS-1:0]   done_q, done_d;
    logic [NUM_ROB_ENTS-1:0]   flag_q, flag_d;
    core_pkg::rob_entry_t      entry_q [NUM_ROB_ENTS];
    core_pkg::rob_entry_t      entry_d [NUM_ROB_ENTS];

    logic [IDXW:0]                       count_s;
    logic                                ready_s;
    logic [DISP_WIDTH-1:0][IDXW-1:0]     alloc_idx_s;
    logic [RETIRE_WIDTH-1:0][IDXW-1:0]   ret_idx_s;
    logic [RETIRE_WIDTH-1:0]             lane_valid_s, lane_done_s, lane_flag_s;
    core_pkg::retire_uop_t [RETIRE_WIDTH-1:0] ret_uop_s;
    logic [RETIRE_WIDTH-1:0]             ret_mask_s;
    logic [CW-1:0]                       ret_cnt_s;
    logic                                sel_flush_s;
    logic [LW-1:0]                       flush_lane_s;
    logic [NUM_FUS-1:0]                  cmpl_cause_s;
    logic [IDXW:0]                       alloc_cnt_s;
    logic                                alloc_run_s;

    // Occupancy, dispatch credit (pre-retire) and tail-relative lane indices.
    always_comb begin
        count_s = tail_q - head_q;
        ready_s = (((IDXW+1)'(NUM_ROB_ENTS) - count_s) >= (IDXW+1)'(DISP_WIDTH));
        for (int i = 0; i < DISP_WIDTH; i++) begin
            alloc_idx_s[i] = tail_q[IDXW-1:0] + IDXW'(i);
        end
    end

    // Gather the oldest RETIRE_WIDTH slots starting at the head.
    always_comb begin
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            ret_idx_s[k]    = head_q[IDXW-1:0] + IDXW'(k);
            lane_valid_s[k] = valid_q[ret_idx_s[k]];
            lane_done_s[k]  = done_q[ret_idx_s[k]];
            lane_flag_s[k]  = flag_q[ret_idx_s[k]];
        end
    end

    rob_retire_sel #(
        .RETIRE_WIDTH (RETIRE_WIDTH)
    ) u_retire_sel (
        .lane_valid (lane_valid_s),
        .lane_done  (lane_done_s),
        .lane_flag  (lane_flag_s),
        .ret_mask   (ret_mask_s),
        .ret_cnt    (ret_cnt_s),
        .flush      (sel_flush_s),
        .flush_lane (flush_lane_s)
    );

    // Build retiring micro-ops; payload is zeroed on lanes that do not retire.
    always_comb begin
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            ret_uop_s[k].valid = ret_mask_s[k];
            if (ret_mask_s[k]) begin
                ret_uop_s[k].areg = entry_q[ret_idx_s[k]].areg;
                ret_uop_s[k].preg = entry_q[ret_idx_s[k]].preg;
                ret_uop_s[k].pc   = entry_q[ret_idx_s[k]].pc;
            end else begin
                ret_uop_s[k].areg = '0;
                ret_uop_s[k].preg = '0;
                ret_uop_s[k].pc   = '0;
            end
        end
    end

    // Drive the external interface from the combinational views above.
    always_comb begin
        disp_ready   = ready_s;
        disp_rob_idx = alloc_idx_s;
        rob_count    = count_s;
        flush        = sel_flush_s;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            ret_valid[k] = ret_uop_s[k].valid;
            ret_areg[k]  = ret_uop_s[k].areg;
            ret_preg[k]  = ret_uop_s[k].preg;
            ret_pc[k]    = ret_uop_s[k].pc;
        end
        if (sel_flush_s) begin
            flush_pc = ret_uop_s[flush_lane_s].pc;
        end else begin
            flush_pc = 32'h0000_0000;
        end
    end

    // Classify each completion port as flush-causing or not.
    always_comb begin
        for (int f = 0; f < NUM_FUS; f++) begin
            cmpl_cause_s[f] = core_pkg::flush_cause(cmpl_exception[f], cmpl_br_mispred[f]);
        end
    end

    // Next state: completions, then retirement, then flush or allocation.
    always_comb begin
        valid_d     = valid_q;
        done_d      = done_q;
        flag_d      = flag_q;
        entry_d     = entry_q;
        tail_d      = tail_q;
        alloc_cnt_s = '0;
        alloc_run_s = 1'b1;

        // Completions only land on live entries and are dropped on a flush.
        if (!sel_flush_s) begin
            for (int f = 0; f < NUM_FUS; f++) begin
                if (cmpl_valid[f] && valid_q[cmpl_rob_idx[f]]) begin
                    done_d[cmpl_rob_idx[f]] = 1'b1;
                    flag_d[cmpl_rob_idx[f]] = flag_d[cmpl_rob_idx[f]] | cmpl_cause_s[f];
                end else begin
                    done_d[cmpl_rob_idx[f]] = done_d[cmpl_rob_idx[f]];
                end
            end
        end else begin
            done_d = done_q;
        end

        // Free the retiring slots.
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            if (ret_mask_s[k]) begin
                valid_d[ret_idx_s[k]] = 1'b0;
                done_d[ret_idx_s[k]]  = 1'b0;
                flag_d[ret_idx_s[k]]  = 1'b0;
            end else begin
                valid_d[ret_idx_s[k]] = valid_d[ret_idx_s[k]];
            end
        end
        head_d = head_q + (IDXW+1)'(ret_cnt_s);

        if (sel_flush_s) begin
            // Everything younger than the flushing entry is discarded.
            valid_d = '0;
            done_d  = '0;
            flag_d  = '0;
            tail_d  = head_d;
        end else if (ready_s) begin
            // Only the contiguous run of valid lanes from lane 0 allocates.
            for (int i = 0; i < DISP_WIDTH; i++) begin
                if (alloc_run_s && disp_valid[i]) begin
                    valid_d[alloc_idx_s[i]] = 1'b1;
                    done_d[alloc_idx_s[i]]  = 1'b0;
                    flag_d[alloc_idx_s[i]]  = 1'b0;
                    entry_d[alloc_idx_s[i]] = disp_entry[i];
                    alloc_cnt_s             = alloc_cnt_s + (IDXW+1)'(1);
                end else begin
                    alloc_run_s = 1'b0;
                end
            end
            tail_d = tail_q + alloc_cnt_s;
        end else begin
            tail_d = tail_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
            flag_q  <= '0;
            for (int i = 0; i < NUM_ROB_ENTS; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            flag_q  <= flag_d;
            entry_q <= entry_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random
// traffic, compared every cycle against a queue-based model of the ROB.
module tb_reorder_buffer;
    import core_pkg::*;

    localparam int N  = 64;
    localparam int IW = 6;
`ifdef ROB_MISPRED_FLUSH_EN
    localparam bit MIS_FLUSHES = 1'b1;
`else
    localparam bit MIS_FLUSHES = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [1:0]                disp_valid;
    rob_entry_t [1:0]          disp_entry;
    logic                      disp_ready;
    logic [1:0][IW-1:0]        disp_rob_idx;
    logic [3:0]                cmpl_valid;
    logic [3:0][IW-1:0]        cmpl_rob_idx;
    logic [3:0]                cmpl_exception;
    logic [3:0]                cmpl_br_mispred;
    logic [3:0]                ret_valid;
    logic [3:0][4:0]           ret_areg;
    logic [3:0][6:0]           ret_preg;
    logic [3:0][31:0]          ret_pc;
    logic                      flush;
    logic [31:0]               flush_pc;
    logic [IW:0]               rob_count;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .disp_valid      (disp_valid),
        .disp_entry      (disp_entry),
        .disp_ready      (disp_ready),
        .disp_rob_idx    (disp_rob_idx),
        .cmpl_valid      (cmpl_valid),
        .cmpl_rob_idx    (cmpl_rob_idx),
        .cmpl_exception  (cmpl_exception),
        .cmpl_br_mispred (cmpl_br_mispred),
        .ret_valid       (ret_valid),
        .ret_areg        (ret_areg),
        .ret_preg        (ret_preg),
        .ret_pc          (ret_pc),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .rob_count       (rob_count)
    );

    // Model: in-flight entries oldest first, plus a tail pointer (0..127).
    typedef struct {
        int          idx;
        logic [4:0]  areg;
        logic [6:0]  preg;
        logic [31:0] pc;
        bit          done;
        bit          flag;
    } m_ent_t;

    m_ent_t mq[$];
    int     m_tail;
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        disp_valid      = '0;
        disp_entry      = '0;
        cmpl_valid      = '0;
        cmpl_rob_idx    = '0;
        cmpl_exception  = '0;
        cmpl_br_mispred = '0;
    endtask

    task automatic set_disp(input int lanes);
        for (int i = 0; i < 2; i++) begin
            disp_valid[i]      = (i < lanes);
            disp_entry[i].areg = 5'($urandom);
            disp_entry[i].preg = 7'($urandom);
            disp_entry[i].pc   = $urandom;
        end
    endtask

    task automatic set_cmpl(input int f, input int idx, input bit e, input bit m);
        cmpl_valid[f]      = 1'b1;
        cmpl_rob_idx[f]    = IW'(idx);
        cmpl_exception[f]  = e;
        cmpl_br_mispred[f] = m;
    endtask

    // One clock: check outputs against the model, advance the model, clock.
    task automatic step(input bit do_rst);
        int     n;
        bit     fl;
        bit     rdy;
        int     head;
        m_ent_t e;
        rst_n = do_rst ? 1'b0 : 1'b1;
        @(negedge clk);
        n  = 0;
        fl = 1'b0;
        for (int k = 0; k < 4 && k < mq.size(); k++) begin
            if (!mq[k].done) break;
            n++;
            if (mq[k].flag) begin
                fl = 1'b1;
                break;
            end
        end
        rdy = ((N - mq.size()) >= 2);
        chk("rob_count", 64'(rob_count), 64'(mq.size()));
        chk("disp_ready", 64'(disp_ready), 64'(rdy));
        chk("disp_idx0", 64'(disp_rob_idx[0]), 64'(m_tail % N));
        chk("disp_idx1", 64'(disp_rob_idx[1]), 64'((m_tail + 1) % N));
        chk("ret_valid", 64'(ret_valid), 64'((1 << n) - 1));
        chk("flush", 64'(flush), 64'(fl));
        chk("flush_pc", 64'(flush_pc), fl ? 64'(mq[n-1].pc) : 64'd0);
        for (int k = 0; k < n; k++) begin
            chk("ret_areg", 64'(ret_areg[k]), 64'(mq[k].areg));
            chk("ret_preg", 64'(ret_preg[k]), 64'(mq[k].preg));
            chk("ret_pc", 64'(ret_pc[k]), 64'(mq[k].pc));
        end
        if (do_rst) begin
            mq.delete();
            m_tail = 0;
        end else if (fl) begin
            head   = (m_tail - mq.size() + 2 * N) % (2 * N);
            m_tail = (head + n) % (2 * N);
            mq.delete();
        end else begin
            for (int f = 0; f < 4; f++) begin
                if (cmpl_valid[f]) begin
                    for (int j = 0; j < mq.size(); j++) begin
                        if (mq[j].idx == int'(cmpl_rob_idx[f])) begin
                            e      = mq[j];
                            e.done = 1'b1;
                            e.flag = e.flag | cmpl_exception[f] | (cmpl_br_mispred[f] & MIS_FLUSHES);
                            mq[j]  = e;
                        end
                    end
                end
            end
            repeat (n) void'(mq.pop_front());
            if (rdy) begin
                for (int i = 0; i < 2; i++) begin
                    if (!disp_valid[i]) break;
                    e.idx  = m_tail % N;
                    e.areg = disp_entry[i].areg;
                    e.preg = disp_entry[i].preg;
                    e.pc   = disp_entry[i].pc;
                    e.done = 1'b0;
                    e.flag = 1'b0;
                    mq.push_back(e);
                    m_tail = (m_tail + 1) % (2 * N);
                end
            end
        end
        @(posedge clk);
        #1;
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic rand_cycle();
        int idx;
        set_disp($urandom_range(0, 2));
        for (int f = 0; f < 4; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                if (mq.size() > 0 && $urandom_range(0, 7) != 0)
                    idx = mq[$urandom_range(0, mq.size() - 1)].idx;
                else
                    idx = $urandom_range(0, N - 1);
                set_cmpl(f, idx, $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0);
            end
        end
        step(1'b0);
    endtask

    // Complete everything outstanding (no flags) until the ROB empties.
    task automatic drain();
        int f;
        for (int t = 0; t < 200 && mq.size() > 0; t++) begin
            f = 0;
            for (int j = 0; j < mq.size() && f < 4; j++) begin
                if (!mq[j].done) begin
                    set_cmpl(f, mq[j].idx, 1'b0, 1'b0);
                    f++;
                end
            end
            step(1'b0);
        end
        @(negedge clk);
        chk("drain_empty", 64'(rob_count), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        rst_n  = 1'b0;
        m_tail = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(rob_count), 64'd0);
        chk("rst_ready", 64'(disp_ready), 64'd1);
        chk("rst_ret_valid", 64'(ret_valid), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_flush_pc", 64'(flush_pc), 64'd0);
        rst_n = 1'b1;

        // Three cycles of dual dispatch, then completions 1,2,0 together.
        repeat (3) begin
            set_disp(2);
            step(1'b0);
        end
        set_cmpl(0, 1, 1'b0, 1'b0);
        set_cmpl(1, 2, 1'b0, 1'b0);
        set_cmpl(2, 0, 1'b0, 1'b0);
        step(1'b0);
        step(1'b0);

        repeat (300) rand_cycle();
        drain();

        // Fill from index 0, retire four, then dispatch across the wrap.
        step(1'b1);
        for (int t = 0; t < 40 && mq.size() < N; t++) begin
            set_disp(2);
            step(1'b0);
        end
        step(1'b0);
        for (int f = 0; f < 4; f++) set_cmpl(f, mq[f].idx, 1'b0, 1'b0);
        step(1'b0);
        set_disp(2);
        step(1'b0);
        step(1'b0);
        drain();

        // Exception on the second of four done entries.
        repeat (2) begin
            set_disp(2);
            step(1'b0);
        end
        for (int f = 0; f < 4; f++) set_cmpl(f, mq[f].idx, f == 1, 1'b0);
        step(1'b0);
        step(1'b0);
        step(1'b0);

        // Mispredict on the head entry.
        set_disp(1);
        step(1'b0);
        set_cmpl(0, mq[0].idx, 1'b0, 1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        drain();

        // Reset with 20 live entries.
        repeat (10) begin
            set_disp(2);
            step(1'b0);
        end
        step(1'b1);
        step(1'b0);

        repeat (400) begin
            if ($urandom_range(0, 99) == 0) step(1'b1);
            else rand_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
